// File: rtl/serial_adder_subtractor_pkg.sv
// Shared encodings for the bit-serial adder/subtractor and the register controller.
package serial_adder_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : serial_adder_subtractor_pkg

// File: rtl/full_adder_1b.sv
// One-bit full adder; the whole arithmetic core of the serial datapath.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder_1b

// File: rtl/serial_adder_subtractor.sv
// Bit-serial A+B / A-B, LSB first, one bit per clock through a single full adder.
// Bit-identical to the combinational adder_subtractor, WIDTH+1 cycle issue rate.
module serial_adder_subtractor
    import serial_adder_subtractor_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] factor_a,
    input  logic [WIDTH-1:0] factor_b,
    input  logic             operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    state_t             state;
    state_t             state_nxt;
    logic               load_c;
    logic               shift_c;
    logic               last_bit_c;

    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   sh_r;
    logic               c_reg;
    logic               c_msb_in;
    logic [CNT_W-1:0]   cnt;

    logic               sum_bit;
    logic               c_next;

    assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));

    full_adder_1b u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (c_reg),
        .s    (sum_bit),
        .cout (c_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; DONE accepts start directly for back-to-back issue
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_c = 1'b1;
                if (last_bit_c) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_SHIFT);
            done <= (state_nxt == ST_DONE);
        end
    end

    // Operand/result shifters; subtraction preloads ~B with carry-in 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a      <= '0;
            sh_b      <= '0;
            sh_r      <= '0;
            c_reg     <= 1'b0;
            c_msb_in  <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (load_c) begin
            sh_a  <= factor_a;
            sh_b  <= (operation == OP_SUB) ? ~factor_b : factor_b;
            c_reg <= operation;
            cnt   <= '0;
        end else if (shift_c) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            sh_r  <= {sum_bit, sh_r[WIDTH-1:1]};
            c_reg <= c_next;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 2)) begin
                c_msb_in <= c_next;
            end
            if (last_bit_c) begin
                result    <= {sum_bit, sh_r[WIDTH-1:1]};
                carry_out <= c_next;
                overflow  <= c_msb_in ^ c_next;
            end
        end
    end

endmodule : serial_adder_subtractor

// File: doc/serial_adder_subtractor.md
Name: serial_adder_subtractor

Overview:
Bit-serial, multi-cycle counterpart of the combinational 8-bit adder_subtractor.
- Accepts two two's-complement operands and an operation select through a start/busy/done handshake.
- Produces the sum or difference LSB-first, one bit per clock, through a 1-bit full adder.
- Sits in the register datapath where area matters more than latency. Results must be bit-identical to adder_subtractor for the same inputs.

Parameters:
WIDTH, 8, operand/result width in bits (must be >= 2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
factor_a  input  WIDTH  operand A, latched when start is accepted
factor_b  input  WIDTH  operand B, latched when start is accepted
operation  input  1  0 = A+B, 1 = A-B; latched when start is accepted
busy  output  1  high while bits are being computed
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  A±B modulo 2^WIDTH; held until next accepted start
carry_out  output  1  final carry (for subtract: 1 = no borrow)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
  - rst_n low forces state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, counter=0, internal shift registers=0.
  - This applies immediately, including mid-operation. A computation interrupted by reset is discarded and no done is produced.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0. If start=1 at a rising edge:
    - latch A into sh_a.
    - latch B into sh_b, or ~B when operation=1.
    - carry register = operation.
    - counter = 0.
    - go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - sum bit = sh_a[0]^sh_b[0]^c.
    - shift the sum bit into the result shift register MSB-side, shift sh_a and sh_b right by one.
    - c = majority(sh_a[0], sh_b[0], c).
    - counter++.
    - On the edge processing bit WIDTH-2, also record that bit's carry-out as c_msb_in.
    - On the edge processing bit WIDTH-1, register result, carry_out=c_next, overflow=c_msb_in^c_next, then go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle.
    - If start=1 at that edge, latch new operands and go to SHIFT (back-to-back; no idle bubble).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0; busy high from E0 to E(WIDTH); done high for the cycle following E(WIDTH).
  - WIDTH=8 gives a 9-cycle start-to-done interval, a 9-cycle issue rate back-to-back.
- start while busy (SHIFT) is ignored. Operand inputs may change freely after acceptance.
- result, carry_out and overflow change only at the final SHIFT edge or on reset. They are not disturbed by a new start until that computation completes.
- Arithmetic is unsigned bit-level, interpreted two's-complement. Wrap-around is modulo 2^WIDTH, never saturates.
  - Subtraction is A + ~B + 1.

Decomposition:
- Shared package (or header of localparams): state encoding ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2, plus OP_ADD=1'b0 and OP_SUB=1'b1. Both are reused by the register controller.
- One natural sub-module: full_adder_1b (a, b, cin -> s, cout), instantiated once in the datapath.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset mid-operation: pulse rst_n low during SHIFT cycle 3 -> all outputs 0 immediately, state IDLE, no done pulse. Then A=0x36, B=0x15, op=0 -> result=0x4B, carry_out=0, overflow=0, done exactly 9 cycles after start.
- Subtract, no overflow: A=0x36, B=0x15, op=1 -> result=0x21, carry_out=1, overflow=0.
- Add, wrap-around: A=0xB8, B=0x57, op=0 -> result=0x0F, carry_out=1, overflow=0.
- Subtract, signed overflow: A=0xB8, B=0x57, op=1 -> result=0x61, carry_out=1, overflow=1.
- Handshake edges:
  - Assert start during SHIFT with A=0xFF -> ignored; result matches the original operands.
  - Assert start in the DONE cycle with A=0x7F, B=0x01, op=0 -> accepted, no IDLE cycle; result=0x80, overflow=1, carry_out=0.
- Randomised compare: 200 random A/B/op against the combinational adder_subtractor -> result identical each time; carry/overflow equal a reference 9-bit model.
